// File: rtl/qed_inst_constraint_seq.sv
// Stateful SQED instruction filter: legality decode, program-length bound, stall-hold check, sticky violation flag.
// Build option: define QED_ASSUME_EN to emit a formal assumption that every valid instruction is legal.
module qed_inst_constraint_seq #(
    parameter int unsigned NUM_ORIG_REGS = 16,
    parameter int unsigned LD_WINDOW     = 64,
    parameter int unsigned ST_WINDOW     = 64,
    parameter bit          ALLOW_SW      = 1'b0,
    parameter bit          ALLOW_MUL     = 1'b0,
    parameter int unsigned MAX_INSTS     = 8,
    parameter int unsigned DRAIN_CYCLES  = 4,
    localparam int unsigned CNT_W = (MAX_INSTS == 0) ? 1 : $clog2(MAX_INSTS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instruction,
    input  logic             inst_valid,
    input  logic             stall,
    output logic             inst_ok,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [1:0]       state,
    output logic             done,
    output logic             viol
);

    localparam int unsigned DRN_W = (DRAIN_CYCLES <= 1) ? 1 : $clog2(DRAIN_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_ISSUE = 2'b00,
        S_DRAIN = 2'b01,
        S_DONE  = 2'b10
    } state_t;

    // Instruction fields
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [11:0] imm_i;
    logic [11:0] imm_s;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign funct7 = instruction[31:25];
    assign imm_i  = instruction[31:20];
    assign imm_s  = {instruction[31:25], instruction[11:7]};

    logic cls_legal;
    logic is_nop;
    logic use_rd;
    logic use_rs1;
    logic use_rs2;

    always_comb begin
        cls_legal = 1'b0;
        is_nop    = 1'b0;
        use_rd    = 1'b0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        case (opcode)
            7'b0010011: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                case (funct3)
                    3'b001:  cls_legal = (funct7 == 7'b0000000);
                    3'b101:  cls_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    default: cls_legal = 1'b1;
                endcase
            end
            7'b0110011: begin
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                case (funct7)
                    7'b0000000: cls_legal = 1'b1;
                    7'b0100000: cls_legal = (funct3 == 3'b000) || (funct3 == 3'b101);
                    // MUL/MULH/MULHSU/MULHU only; divides stay illegal
                    7'b0000001: cls_legal = ALLOW_MUL && !funct3[2];
                    default:    cls_legal = 1'b0;
                endcase
            end
            7'b0000011: begin
                use_rd    = 1'b1;
                use_rs1   = 1'b1;
                cls_legal = (funct3 == 3'b010) && (rs1 == 5'd0) && (32'(imm_i) < LD_WINDOW);
            end
            7'b0100011: begin
                use_rs1   = 1'b1;
                use_rs2   = 1'b1;
                cls_legal = ALLOW_SW && (funct3 == 3'b010) && (rs1 == 5'd0)
                            && (32'(imm_s) < ST_WINDOW);
            end
            7'b1111111: begin
                is_nop    = 1'b1;
                cls_legal = 1'b1;
            end
            default: cls_legal = 1'b0;
        endcase
    end

    // Register-bound checks, one per operand slot
    logic [4:0] reg_field [3];
    logic [2:0] reg_used;
    logic [2:0] reg_ok;

    assign reg_field[0] = rd;
    assign reg_field[1] = rs1;
    assign reg_field[2] = rs2;
    assign reg_used     = {use_rs2, use_rs1, use_rd};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_reg_bound
            assign reg_ok[gi] = !reg_used[gi] || (32'(reg_field[gi]) < NUM_ORIG_REGS);
        end
    endgenerate

    logic legal;
    assign legal = cls_legal && (&reg_ok);

    // State
    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [DRN_W-1:0]   drain_cnt_reg, drain_cnt_next;
    logic               hold_pend_reg, hold_pend_next;
    logic [31:0]        held_word_reg, held_word_next;
    logic               done_reg, done_next;
    logic               viol_reg, viol_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_ISSUE;
            cnt_reg       <= '0;
            drain_cnt_reg <= '0;
            hold_pend_reg <= 1'b0;
            held_word_reg <= '0;
            done_reg      <= 1'b0;
            viol_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            drain_cnt_reg <= drain_cnt_next;
            hold_pend_reg <= hold_pend_next;
            held_word_reg <= held_word_next;
            done_reg      <= done_next;
            viol_reg      <= viol_next;
        end
    end

    // While rst is high, legality is judged as if already reset
    state_t eff_state;
    logic   hold_active;
    logic   hold_ok;
    logic   accept;

    assign eff_state   = rst ? S_ISSUE : state_reg;
    assign hold_active = !rst && hold_pend_reg;
    assign hold_ok     = !hold_active || (inst_valid && (instruction == held_word_reg));
    assign accept      = inst_valid && !stall;

    logic [CNT_W-1:0] cnt_inc;
    assign cnt_inc = cnt_reg + 1'b1;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        drain_cnt_next = drain_cnt_reg;
        hold_pend_next = inst_valid && stall;
        held_word_next = (inst_valid && stall) ? instruction : held_word_reg;
        viol_next      = viol_reg || (inst_valid && !inst_ok);
        case (state_reg)
            S_ISSUE: begin
                drain_cnt_next = '0;
                if (accept && !is_nop) begin
                    if (MAX_INSTS == 0) begin
                        if (cnt_reg != CNT_MAX) begin
                            cnt_next = cnt_inc;
                        end
                    end else begin
                        cnt_next = cnt_inc;
                        if (32'(cnt_inc) == MAX_INSTS) begin
                            state_next = S_DRAIN;
                        end
                    end
                end
            end
            S_DRAIN: begin
                // Drain time runs regardless of stall
                if (32'(drain_cnt_reg) + 32'd1 >= DRAIN_CYCLES) begin
                    state_next = S_DONE;
                end else begin
                    drain_cnt_next = drain_cnt_reg + 1'b1;
                end
            end
            S_DONE:  state_next = S_DONE;
            default: state_next = S_ISSUE;
        endcase
        done_next = (state_next == S_DONE);
    end

    always_comb begin
        inst_ok    = legal && hold_ok && ((eff_state == S_ISSUE) || is_nop);
        issued_cnt = cnt_reg;
        state      = state_reg;
        done       = done_reg;
        viol       = viol_reg;
    end

`ifdef QED_ASSUME_EN
    assume_legal_stream: assume property (@(posedge clk) disable iff (rst) !inst_valid || inst_ok);
`else
`endif

endmodule

// File: tb/tb_qed_inst_constraint_seq.sv
// Directed bench for qed_inst_constraint_seq: decode table, hold rule, drain/done sequencing, reset, saturation.
module tb_qed_inst_constraint_seq;

    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic        inst_valid;
    logic        stall;

    logic        ok0, done0, viol0;
    logic [1:0]  cnt0, state0;
    logic        ok1, done1, viol1;
    logic [0:0]  cnt1;
    logic [1:0]  state1;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [31:0] W_ADDI    = 32'h00508193;
    localparam logic [31:0] W_ADDI_X4 = 32'h00100213;
    localparam logic [31:0] W_ADD_X17 = 32'h002088B3;
    localparam logic [31:0] W_NOP     = 32'h0000007F;

    qed_inst_constraint_seq #(
        .MAX_INSTS    (2),
        .DRAIN_CYCLES (3)
    ) u0 (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .inst_valid  (inst_valid),
        .stall       (stall),
        .inst_ok     (ok0),
        .issued_cnt  (cnt0),
        .state       (state0),
        .done        (done0),
        .viol        (viol0)
    );

    qed_inst_constraint_seq #(
        .ALLOW_MUL (1'b1),
        .MAX_INSTS (0)
    ) u1 (
        .clk         (clk),
        .rst         (rst),
        .instruction (instruction),
        .inst_valid  (inst_valid),
        .stall       (stall),
        .inst_ok     (ok1),
        .issued_cnt  (cnt1),
        .state       (state1),
        .done        (done1),
        .viol        (viol1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] w, input logic v, input logic s);
        instruction = w;
        inst_valid  = v;
        stall       = s;
        #1;
    endtask

    logic [31:0] dec_word [14];
    logic        dec_exp0 [14];
    logic        dec_exp1 [14];

    initial begin
        dec_word = '{32'h00508193, 32'h002088B3, 32'h023100B3, 32'h0000007F,
                     32'h03F02283, 32'h04002283, 32'h0080A283, 32'h00202023,
                     32'h4030D093, 32'h40309093, 32'h00078093, 32'h00080093,
                     32'h00000017, 32'h023130B3};
        dec_exp0 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        dec_exp1 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

        rst = 1'b1;
        drive(W_NOP, 1'b0, 1'b0);
        tick();
        drive(W_ADDI, 1'b0, 1'b0);
        chk("ok_during_rst", ok0, 1);
        tick();
        rst = 1'b0;
        chk("rst_cnt", cnt0, 0);
        chk("rst_state", state0, 0);
        chk("rst_done", done0, 0);
        chk("rst_viol", viol0, 0);

        // Pure decode, nothing presented
        for (int i = 0; i < 14; i++) begin
            drive(dec_word[i], 1'b0, 1'b0);
            chk($sformatf("dec%0d_u0", i), ok0, dec_exp0[i]);
            chk($sformatf("dec%0d_u1", i), ok1, dec_exp1[i]);
        end

        // ADDI accepted
        tick();
        drive(W_ADDI, 1'b1, 1'b0);
        chk("addi_ok", ok0, 1);
        tick();
        chk("addi_cnt", cnt0, 1);
        chk("addi_viol", viol0, 0);

        // Out-of-range rd sets sticky viol
        drive(W_ADD_X17, 1'b1, 1'b0);
        chk("rd17_ok", ok0, 0);
        tick();
        drive(W_NOP, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("viol_hold%0d", i), viol0, 1);
            tick();
        end

        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_viol", viol0, 0);
        chk("rst2_cnt", cnt0, 0);

        // Hold rule while stalled
        drive(W_ADDI, 1'b1, 1'b1);
        chk("hold1_ok", ok0, 1);
        tick();
        drive(W_ADDI, 1'b1, 1'b1);
        chk("hold2_ok", ok0, 1);
        tick();
        drive(W_ADDI_X4, 1'b1, 1'b1);
        chk("hold_chg_ok", ok0, 0);
        tick();
        chk("hold_viol", viol0, 1);
        chk("hold_cnt", cnt0, 0);
        drive(W_ADDI_X4, 1'b1, 1'b0);
        chk("hold_rel_ok", ok0, 1);
        tick();
        chk("rel_cnt", cnt0, 1);
        drive(W_ADDI, 1'b1, 1'b0);
        chk("acc2_ok", ok0, 1);
        tick();
        chk("drain_cnt", cnt0, 2);
        chk("drain_state", state0, 1);
        chk("drain_done", done0, 0);

        // Drain: only NOP legal; DONE three cycles after entry
        drive(W_ADDI, 1'b1, 1'b0);
        chk("drain_addi_ok", ok0, 0);
        drive(W_NOP, 1'b1, 1'b0);
        chk("drain_nop_ok", ok0, 1);
        tick();
        drive(W_NOP, 1'b0, 1'b0);
        chk("drain1_state", state0, 1);
        chk("drain1_done", done0, 0);
        tick();
        chk("drain2_state", state0, 1);
        chk("drain2_done", done0, 0);
        tick();
        chk("done_state", state0, 2);
        chk("done_done", done0, 1);
        chk("done_cnt", cnt0, 2);
        drive(W_ADDI, 1'b0, 1'b0);
        chk("done_addi_ok", ok0, 0);
        tick();
        chk("done_stays", state0, 2);

        // Reset in DRAIN, with a simultaneous valid instruction
        rst = 1'b1;
        drive(W_NOP, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        drive(W_ADDI, 1'b1, 1'b0);
        tick();
        drive(W_ADDI, 1'b1, 1'b0);
        tick();
        chk("d2_state", state0, 1);
        drive(W_ADDI, 1'b1, 1'b0);
        tick();
        chk("d2_viol", viol0, 1);
        rst = 1'b1;
        drive(W_ADDI, 1'b1, 1'b0);
        chk("rst_drain_ok", ok0, 1);
        tick();
        rst = 1'b0;
        drive(W_NOP, 1'b0, 1'b0);
        chk("rstd_state", state0, 0);
        chk("rstd_cnt", cnt0, 0);
        chk("rstd_viol", viol0, 0);
        chk("rstd_done", done0, 0);

        // Unbounded instance saturates and never leaves ISSUE
        for (int i = 0; i < 3; i++) begin
            drive(W_ADDI, 1'b1, 1'b0);
            tick();
        end
        drive(W_NOP, 1'b0, 1'b0);
        chk("sat_cnt", cnt1, 1);
        chk("sat_state", state1, 0);
        chk("sat_done", done1, 0);
        chk("sat_viol", viol1, 0);
        chk("u0_cnt_end", cnt0, 2);
        chk("u0_state_end", state0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
